// File: rtl/line_window_buffer.sv
// Multi-channel vertical window line buffer: current pixel plus co-located pixels of the
// previous BUF_DEPTH-1 lines. Optional macro LINEBUF_BORDER_REPLICATE_EN replicates the top border.
module line_window_buffer #(
    parameter int  COLORDEPTH  = 8,
    parameter int  CHANNELS    = 3,
    parameter int  SCREENWIDTH = 1600,
    parameter int  BUF_DEPTH   = 3,
    localparam int PW          = CHANNELS * COLORDEPTH,
    localparam int AW          = $clog2(SCREENWIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PW-1:0]        data_i,
    input  logic                 dv_i,
    input  logic                 sof_i,
    input  logic                 eol_i,
    output logic [PW-1:0]        buff_o [BUF_DEPTH-1:0],
    output logic                 dv_o,
    output logic                 sof_o,
    output logic                 eol_o,
    output logic [BUF_DEPTH-2:0] line_valid_o,
    output logic                 overflow_o
);

    localparam int              MW       = (SCREENWIDTH > 1) ? $clog2(SCREENWIDTH) : 1;
    localparam int              FW       = $clog2(BUF_DEPTH);
    localparam logic [AW-1:0]   ADDR_END = AW'(SCREENWIDTH);
    localparam logic [FW-1:0]   FILL_MAX = FW'(BUF_DEPTH - 1);

    logic [AW-1:0]        addr_q, addr_d, a_eff;
    logic [FW-1:0]        fill_q, fill_d, fill_eff;
    logic                 overflow_q, overflow_d;
    logic                 dv_q, dv_d, sof_q, sof_d, eol_q, eol_d;
    logic [BUF_DEPTH-2:0] lv_q, lv_d;
    logic [PW-1:0]        buff_q [BUF_DEPTH-1:0];
    logic [PW-1:0]        buff_d [BUF_DEPTH-1:0];
    logic [PW-1:0]        raw_tap [BUF_DEPTH-1:0];
    logic                 in_range, wr_en;
    logic [MW-1:0]        col;

    // A start-of-frame pixel always lands in column 0 of a fresh, empty window.
    assign a_eff    = sof_i ? '0 : addr_q;
    assign fill_eff = sof_i ? '0 : fill_q;
    assign in_range = (a_eff != ADDR_END);
    assign wr_en    = dv_i && in_range;
    assign col      = a_eff[MW-1:0];

    assign raw_tap[0] = data_i;

    for (genvar k = 1; k < BUF_DEPTH; k++) begin : g_line
        logic [PW-1:0] mem_q [SCREENWIDTH];

        assign raw_tap[k] = mem_q[col];

        // NOTE: line memories have no reset; masking keeps stale contents from reaching buff_o.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[col] <= raw_tap[k-1];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
        addr_d     = addr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        dv_d       = 1'b0;
        sof_d      = 1'b0;
        eol_d      = 1'b0;
        lv_d       = lv_q;
        buff_d     = buff_q;

        if (dv_i) begin
            if (sof_i) begin
                overflow_d = 1'b0;
            end
            if (!in_range) begin
                overflow_d = 1'b1;
            end

            if (eol_i) begin
                addr_d = '0;
                fill_d = (fill_eff == FILL_MAX) ? fill_eff : fill_eff + 1'b1;
            end else begin
                addr_d = in_range ? a_eff + 1'b1 : a_eff;
                fill_d = fill_eff;
            end

            if (in_range) begin
                dv_d      = 1'b1;
                sof_d     = sof_i;
                eol_d     = eol_i;
                buff_d[0] = raw_tap[0];
                for (int k = 1; k < BUF_DEPTH; k++) begin
                    lv_d[k-1] = (fill_eff >= FW'(k));
                    if (fill_eff >= FW'(k)) begin
                        buff_d[k] = raw_tap[k];
                    end else begin
`ifdef LINEBUF_BORDER_REPLICATE_EN
                        buff_d[k] = raw_tap[fill_eff];
`else
                        buff_d[k] = '0;
`endif
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            dv_q       <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            lv_q       <= '0;
            for (int k = 0; k < BUF_DEPTH; k++) begin
                buff_q[k] <= '0;
            end
        end else begin
            addr_q     <= addr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            dv_q       <= dv_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            lv_q       <= lv_d;
            buff_q     <= buff_d;
        end
    end

    assign buff_o       = buff_q;
    assign dv_o         = dv_q;
    assign sof_o        = sof_q;
    assign eol_o        = eol_q;
    assign line_valid_o = lv_q;
    assign overflow_o   = overflow_q;

endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised multi-channel vertical window line buffer for the pixel pipeline. It accepts a pixel stream with frame and line markers and presents the current pixel plus the co-located pixels of the previous BUF_DEPTH-1 lines as a registered tap column. It sits between the video input/colour stages and the spatial filter kernels. It improves on the fixed buffer it replaces: the address advances only on valid pixels, the line count is tracked per frame, line overflow is guarded, and unfilled lines at the top of a frame are masked.

## Interface
- COLORDEPTH, 8, bits per channel
- CHANNELS, 3, channels per pixel, packed with channel 0 in the LSBs
- SCREENWIDTH, 1600, maximum pixels per line, which is also the memory depth
- BUF_DEPTH, 3, number of taps: the current line plus BUF_DEPTH-1 stored lines, must be ≥2
- PW (derived), CHANNELS*COLORDEPTH; AW (derived), $clog2(SCREENWIDTH+1)
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- data_i  in  PW  input pixel
- dv_i  in  1  input pixel valid
- sof_i  in  1  first pixel of frame, qualified by dv_i
- eol_i  in  1  last pixel of line, qualified by dv_i
- buff_o  out  PW×BUF_DEPTH (unpacked [BUF_DEPTH-1:0])  tap k = pixel k lines above the current one
- dv_o  out  1  taps valid
- sof_o, eol_o  out  1  markers delayed to align with dv_o
- line_valid_o  out  BUF_DEPTH-1  bit k-1 set when tap k holds a real line of the current frame
- overflow_o  out  1  sticky flag: a line exceeded SCREENWIDTH pixels

## Operation
- Column address addr (AW bits) advances by 1 only on an accepted pixel (dv_i=1).
- Stored line k (k=1..BUF_DEPTH-1) has its own SCREENWIDTH×PW memory. For an accepted pixel at addr a:
  - read mem_k[a] (old data) → tap k
  - write tap k-1 into mem_k[a]; tap 0 = data_i
  - the read is read-before-write at the same address.
- sof_i with dv_i:
  - this pixel uses a=0
  - line count fill is cleared to 0
  - overflow_o is cleared
- eol_i with dv_i:
  - addr returns to 0 after this pixel
  - fill increments, saturating at BUF_DEPTH-1
- sof_i and eol_i together on one pixel means a 1-pixel line: both actions apply, and fill ends at 1.
- Markers without dv_i are ignored.
- Overflow: an accepted pixel arriving with addr==SCREENWIDTH without eol_i is not written and produces no dv_o. overflow_o is set and addr holds. eol_i on such a pixel still ends the line normally.
- Masking: tap k with k>fill is not a real line. It outputs zero, or the replicated line described under Configuration.
- line_valid_o[k-1] = (fill ≥ k).

## Timing
- Latency is 1 cycle. buff_o, dv_o, sof_o, eol_o and line_valid_o register together the cycle after an accepted pixel.
- dv_o is 0 on cycles with no accepted pixel. buff_o holds its last value.
- Back-to-back pixels at 1 per clock are supported, with no bubbles required, including across eol→next line.
- Reset values: all buff_o 0, dv_o 0, sof_o 0, eol_o 0, line_valid_o 0, overflow_o 0, addr 0, fill 0.
- Memory contents are not reset. Stale data is never exposed because of masking.
- Reset asserted mid-line drops the line. The first line after reset counts as fill=0 even without sof_i.

## Configuration
- LINEBUF_BORDER_REPLICATE_EN
  - Defined: a masked tap k (k>fill) outputs the value of tap fill, i.e. the oldest real line. At fill=0 every tap outputs data_i, which replicates the top border.
  - Undefined: masked taps output all-zero.
- line_valid_o is identical in both builds.

## Test plan
Bench parameters: COLORDEPTH=8, CHANNELS=2, SCREENWIDTH=8, BUF_DEPTH=3.
- Reset: assert rst asynchronously mid-line → all outputs 0 immediately. After release, a 4-pixel line gives dv_o pulses with line_valid_o=2'b00.
- Fill: sof, then three 8-pixel lines with pixel = {line,col}.
  - On line 2, col 5: buff_o[0]=16'h0205, buff_o[1]=16'h0105, buff_o[2]=16'h0005, line_valid_o=2'b11.
  - line_valid_o reads 2'b00 on line 0 and 2'b01 on line 1.
- Gapped input: dv_i toggled 1/0 across a line → taps are column-aligned exactly as in the gap-free case. dv_o follows dv_i delayed by 1.
- Masking on line 0 col 3 (pixel 16'h0003):
  - without macro, buff_o[1]=buff_o[2]=0
  - with LINEBUF_BORDER_REPLICATE_EN, both equal 16'h0003
- Overflow: 10 pixels with no eol → 8 dv_o pulses and overflow_o=1 from the 9th pixel. The next sof clears overflow_o.
- Marker edges:
  - sof+eol on one pixel → fill=1, and the next line has line_valid_o=2'b01
  - a mid-frame sof resets line_valid_o to 2'b00
